// File: rtl/ascii_rom.sv
// 64-entry 8x16 glyph ROM: digits, '-', A..Z and blanks, addressed as {code, row}.
// Optional one-cycle output register with asynchronous clear.
module ascii_rom #(
    parameter int REGISTERED = 0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [9:0] addr_i,
    output logic [7:0] data_o
);

    logic [5:0]      code;
    logic [3:0]      row;
    logic [9:0][7:0] glyph;
    logic [7:0]      rom_row;

    assign code = addr_i[9:4];
    assign row  = addr_i[3:0];

    // glyph[9] is glyph row 2, glyph[0] is glyph row 11; bit 0 is always a spacing column
    always_comb begin
        glyph = '0;
        case (code)
            6'd0:  glyph = {8'h38, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h38};
            6'd1:  glyph = {8'h10, 8'h30, 8'h50, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h7C};
            6'd2:  glyph = {8'h7C, 8'h82, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'hFE};
            6'd3:  glyph = {8'h7C, 8'h82, 8'h02, 8'h02, 8'h3C, 8'h02, 8'h02, 8'h02, 8'h82, 8'h7C};
            6'd4:  glyph = {8'h04, 8'h0C, 8'h14, 8'h24, 8'h44, 8'h84, 8'hFE, 8'h04, 8'h04, 8'h04};
            6'd5:  glyph = {8'hFE, 8'h80, 8'h80, 8'h80, 8'hFC, 8'h02, 8'h02, 8'h02, 8'h82, 8'h7C};
            6'd6:  glyph = {8'h7C, 8'h82, 8'h80, 8'h80, 8'hFC, 8'h82, 8'h82, 8'h82, 8'h82, 8'h7C};
            6'd7:  glyph = {8'hFE, 8'h02, 8'h04, 8'h04, 8'h08, 8'h08, 8'h10, 8'h10, 8'h10, 8'h10};
            6'd8:  glyph = {8'h7C, 8'h82, 8'h82, 8'h82, 8'h7C, 8'h82, 8'h82, 8'h82, 8'h82, 8'h7C};
            6'd9:  glyph = {8'h7C, 8'h82, 8'h82, 8'h82, 8'h82, 8'h7E, 8'h02, 8'h02, 8'h82, 8'h7C};
            6'd10: glyph = {8'h00, 8'h00, 8'h00, 8'h00, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
            6'd11: glyph = {8'h10, 8'h28, 8'h44, 8'h82, 8'h82, 8'hFE, 8'h82, 8'h82, 8'h82, 8'h82};
            6'd12: glyph = {8'hFC, 8'h82, 8'h82, 8'h82, 8'hFC, 8'h82, 8'h82, 8'h82, 8'h82, 8'hFC};
            6'd13: glyph = {8'h7C, 8'h82, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h82, 8'h7C};
            6'd14: glyph = {8'hF8, 8'h84, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h84, 8'hF8};
            6'd15: glyph = {8'hFE, 8'h80, 8'h80, 8'h80, 8'hFC, 8'h80, 8'h80, 8'h80, 8'h80, 8'hFE};
            6'd16: glyph = {8'hFE, 8'h80, 8'h80, 8'h80, 8'hFC, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
            6'd17: glyph = {8'h7C, 8'h82, 8'h80, 8'h80, 8'h8E, 8'h82, 8'h82, 8'h82, 8'h86, 8'h7A};
            6'd18: glyph = {8'h82, 8'h82, 8'h82, 8'h82, 8'hFE, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82};
            6'd19: glyph = {8'h7C, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h7C};
            6'd20: glyph = {8'h0E, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h84, 8'h84, 8'h78};
            6'd21: glyph = {8'h82, 8'h84, 8'h88, 8'h90, 8'hE0, 8'h90, 8'h88, 8'h84, 8'h82, 8'h82};
            6'd22: glyph = {8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h7E};
            6'd23: glyph = {8'h82, 8'hC6, 8'hAA, 8'h92, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82};
            6'd24: glyph = {8'h82, 8'hC2, 8'hA2, 8'h92, 8'h8A, 8'h86, 8'h82, 8'h82, 8'h82, 8'h82};
            6'd25: glyph = {8'h7C, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h7C};
            6'd26: glyph = {8'hFC, 8'h82, 8'h82, 8'h82, 8'hFC, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
            6'd27: glyph = {8'h7C, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h92, 8'h8A, 8'h84, 8'h7A};
            6'd28: glyph = {8'hFC, 8'h82, 8'h82, 8'h82, 8'hFC, 8'h90, 8'h88, 8'h84, 8'h82, 8'h82};
            6'd29: glyph = {8'h7C, 8'h82, 8'h80, 8'h80, 8'h7C, 8'h02, 8'h02, 8'h02, 8'h82, 8'h7C};
            6'd30: glyph = {8'hFE, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
            6'd31: glyph = {8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h82, 8'h7C};
            6'd32: glyph = {8'h82, 8'h82, 8'h82, 8'h82, 8'h44, 8'h44, 8'h44, 8'h28, 8'h28, 8'h10};
            6'd33: glyph = {8'h82, 8'h82, 8'h82, 8'h82, 8'h92, 8'h92, 8'h92, 8'hAA, 8'hC6, 8'h82};
            6'd34: glyph = {8'h82, 8'h82, 8'h44, 8'h28, 8'h10, 8'h10, 8'h28, 8'h44, 8'h82, 8'h82};
            6'd35: glyph = {8'h82, 8'h82, 8'h44, 8'h44, 8'h28, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
            6'd36: glyph = {8'hFE, 8'h02, 8'h04, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h40, 8'hFE};
            default: glyph = '0;
        endcase
    end

    always_comb begin
        rom_row = 8'h00;
        if (row >= 4'd2 && row <= 4'd11) begin
            rom_row = glyph[4'd11 - row];
        end
    end

    generate
        if (REGISTERED != 0) begin : g_reg
            logic [7:0] data_q;

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    data_q <= 8'h00;
                end else begin
                    data_q <= rom_row;
                end
            end

            assign data_o = data_q;
        end else begin : g_comb
            // clock and reset are intentionally unused in the combinational build
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk_i, reset_i};
            assign data_o      = rom_row;
        end
    endgenerate

endmodule

// File: tb/tb_ascii_rom.sv
// Checks both read-path builds of ascii_rom against a rule-based glyph model,
// fixed vectors, latency/reset sequences and randomized addresses.
module tb_ascii_rom;

    logic       clk;
    logic       reset;
    logic [9:0] addr_c;
    logic [9:0] addr_r;
    logic [7:0] data_c;
    logic [7:0] data_r;

    int n_checks = 0;
    int n_fail   = 0;

    ascii_rom #(.REGISTERED(0)) dut_comb (
        .clk_i  (clk),
        .reset_i(reset),
        .addr_i (addr_c),
        .data_o (data_c)
    );

    ascii_rom #(.REGISTERED(1)) dut_reg (
        .clk_i  (clk),
        .reset_i(reset),
        .addr_i (addr_r),
        .data_o (data_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] code;
        logic [3:0] row;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    // Rows the requirements pin down; everything else is only constrained by spacing rules.
    function automatic bit model(input logic [9:0] a, output logic [7:0] val);
        int c = int'(a[9:4]);
        int r = int'(a[3:0]);
        val = 8'h00;
        if (r < 2 || r > 11 || c >= 37) return 1'b1;
        case (c)
            30: begin val = (r == 2) ? 8'hFE : 8'h10; return 1'b1; end
            19: begin val = (r == 2 || r == 11) ? 8'h7C : 8'h10; return 1'b1; end
            22: begin val = (r == 11) ? 8'h7E : 8'h40; return 1'b1; end
            10: begin val = (r == 6) ? 8'h7C : 8'h00; return 1'b1; end
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] mirror(input logic [7:0] b);
        return {b[1], b[2], b[3], b[4], b[5], b[6], b[7], 1'b0};
    endfunction

    function automatic bit is_sym_letter(input int c);
        return c == 11 || c == 18 || c == 19 || c == 23 || c == 25 || c == 30 ||
               c == 31 || c == 32 || c == 33 || c == 34 || c == 35;
    endfunction

    function automatic logic [9:0] rand_addr();
        logic [9:0] a;
        int sel = int'($urandom_range(0, 3));
        int r   = int'($urandom_range(0, 15));
        case (sel)
            0: a = {6'd30, r[3:0]};
            1: a = {6'd19, r[3:0]};
            2: a = {6'd22, r[3:0]};
            default: a = 10'($urandom_range(0, 1023));
        endcase
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t       vecs[$];
    logic [7:0] exp;
    logic [7:0] lit[64];
    logic [7:0] exp_q;
    bit         known_q;

    initial begin
        reset  = 1'b1;
        addr_c = {6'd30, 4'd2};
        addr_r = {6'd30, 4'd2};
        #2;
        check("reg_in_reset", data_r, 8'h00);
        check("comb_during_reset", data_c, 8'hFE);

        vecs.push_back('{6'd30, 4'd2,  8'hFE});
        vecs.push_back('{6'd30, 4'd7,  8'h10});
        vecs.push_back('{6'd30, 4'd11, 8'h10});
        vecs.push_back('{6'd30, 4'd12, 8'h00});
        vecs.push_back('{6'd19, 4'd2,  8'h7C});
        vecs.push_back('{6'd19, 4'd5,  8'h10});
        vecs.push_back('{6'd19, 4'd11, 8'h7C});
        vecs.push_back('{6'd22, 4'd2,  8'h40});
        vecs.push_back('{6'd22, 4'd10, 8'h40});
        vecs.push_back('{6'd22, 4'd11, 8'h7E});
        vecs.push_back('{6'd10, 4'd6,  8'h7C});
        vecs.push_back('{6'd10, 4'd5,  8'h00});
        vecs.push_back('{6'd2,  4'd0,  8'h00});
        vecs.push_back('{6'd37, 4'd6,  8'h00});
        vecs.push_back('{6'd63, 4'd15, 8'h00});
        vecs.push_back('{6'd11, 4'd1,  8'h00});
        foreach (vecs[i]) begin
            addr_c = {vecs[i].code, vecs[i].row};
            #1;
            check($sformatf("vec%0d_c%0d_r%0d", i, vecs[i].code, vecs[i].row), data_c, vecs[i].exp);
        end

        // full sweep: spacing rules, pinned glyphs, symmetry, non-empty glyphs
        for (int c = 0; c < 64; c++) begin
            lit[c] = 8'h00;
            for (int r = 0; r < 16; r++) begin
                addr_c = 10'(c * 16 + r);
                #1;
                lit[c] = lit[c] | data_c;
                check($sformatf("bit0_c%0d_r%0d", c, r), {7'd0, data_c[0]}, 8'h00);
                if (model(addr_c, exp)) check($sformatf("model_c%0d_r%0d", c, r), data_c, exp);
                if (is_sym_letter(c)) check($sformatf("sym_c%0d_r%0d", c, r), data_c, mirror(data_c));
            end
            if (c <= 36) check($sformatf("nonempty_c%0d", c), {7'd0, lit[c] != 8'h00}, 8'h01);
        end

        // registered: release reset, back-to-back reads, one-cycle latency
        @(negedge clk);
        reset  = 1'b0;
        addr_r = {6'd30, 4'd2};
        tick();
        check("reg_lat_T2", data_r, 8'hFE);
        addr_r = {6'd19, 4'd2};
        #2;
        check("reg_hold_before_edge", data_r, 8'hFE);
        tick();
        check("reg_lat_I2", data_r, 8'h7C);
        addr_r = 10'd32;
        tick();
        check("reg_addr32", data_r, 8'h00);
        addr_c = 10'd32;
        #1;
        check("comb_addr32", data_c, 8'h00);

        // asynchronous reset mid-cycle while showing FE
        addr_r = {6'd30, 4'd2};
        tick();
        check("reg_pre_reset", data_r, 8'hFE);
        #2;
        reset  = 1'b1;
        #1;
        check("reg_async_clear", data_r, 8'h00);
        addr_r = {6'd19, 4'd2};
        tick();
        check("reg_held_in_reset", data_r, 8'h00);
        @(negedge clk);
        reset  = 1'b0;
        addr_r = {6'd19, 4'd11};
        #1;
        check("reg_after_release_no_edge", data_r, 8'h00);
        tick();
        check("reg_first_edge_after_release", data_r, 8'h7C);

        // randomized: both builds against the model, registered delayed by one cycle
        @(negedge clk);
        addr_r  = rand_addr();
        known_q = model(addr_r, exp_q);
        for (int n = 0; n < 300; n++) begin
            addr_c = rand_addr();
            #1;
            if (model(addr_c, exp)) check($sformatf("rand_comb_%03h", addr_c), data_c, exp);
            check($sformatf("rand_comb_bit0_%03h", addr_c), {7'd0, data_c[0]}, 8'h00);
            tick();
            if (known_q) check($sformatf("rand_reg_n%0d", n), data_r, exp_q);
            check($sformatf("rand_reg_bit0_n%0d", n), {7'd0, data_r[0]}, 8'h00);
            @(negedge clk);
            addr_r  = rand_addr();
            known_q = model(addr_r, exp_q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ascii_rom.md
ASCII_ROM -- requirements
Module: ascii_rom

Interface
REQ-001 SHALL have parameter REGISTERED, default 0; 0 = combinational read path, 1 = one-cycle registered read path.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all sequential logic samples on its rising edge.
REQ-003 SHALL have port reset_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port addr_i, input, 10 bits: glyph row address, bits [9:4] = character code (0..63), bits [3:0] = glyph row (0..15, top to bottom).
REQ-005 SHALL have port data_o, output, 8 bits: pixel row bitmap, bit 7 = leftmost pixel, bit 0 = rightmost pixel, 1 = pixel lit.

Function
REQ-006 SHALL store an 8-wide x 16-tall bitmap glyph for each of the 64 character codes; the content SHALL be constant (ROM) and not writable.
REQ-007 SHALL map codes 0..9 to digits '0'..'9', code 10 to '-', codes 11..36 to 'A'..'Z' (A=11, B=12, ... Y=35, Z=36), and code 37 to space.
REQ-008 SHALL return 8'h00 for every row of code 37 (space) and of unassigned codes 38..63.
REQ-009 SHALL confine every glyph to columns bits 7..1 and rows 2..11; rows 0, 1, 12..15 and bit 0 of every row SHALL be 0 for all codes, giving inter-character and inter-line spacing.
REQ-010 SHALL draw letters as uppercase, stroke width 1 pixel, sans-serif, symmetric about bit 4 where the letter is symmetric.
REQ-011 SHALL use these exact rows for the letter T (code 30): row 2 = 8'hFE, rows 3..11 = 8'h10.
REQ-012 SHALL use these exact rows for the letter I (code 19): row 2 = 8'h7C, rows 3..10 = 8'h10, row 11 = 8'h7C.
REQ-013 SHALL use these exact rows for the letter L (code 22): rows 2..10 = 8'h40, row 11 = 8'h7E.
REQ-014 SHALL use these exact rows for '-' (code 10): row 6 = 8'h7C, all other rows 8'h00.
REQ-015 With REGISTERED=0, data_o SHALL be a pure combinational function of addr_i with zero clock latency; clk_i and reset_i have no effect.
REQ-016 With REGISTERED=1, data_o SHALL update on each rising clk_i edge to the glyph row addressed by addr_i before that edge (latency exactly 1 cycle, new address accepted every cycle).
REQ-017 Address 10'd32 (code 2, row 0) SHALL return 8'h00 in either mode, so a caller parking the address there reads no lit pixel.
REQ-018 All 1024 addresses SHALL be decoded; no address produces X or undefined data.

Reset
REQ-019 With REGISTERED=1, asserting reset_i SHALL immediately (without waiting for a clock edge) force data_o to 8'h00 and hold it while reset_i is high.
REQ-020 With REGISTERED=1, the first rising clk_i edge after reset_i deasserts SHALL load the row addressed at that edge; reset asserted mid-stream discards the pending read.
REQ-021 With REGISTERED=0, there SHALL be no reset-dependent state; data_o follows addr_i during and after reset.

Verification
REQ-022 REGISTERED=0, addr_i = {6'd30, 4'd2} -> data_o = 8'hFE same cycle; addr_i = {6'd30, 4'd7} -> 8'h10.
REQ-023 REGISTERED=0, sweep all 16 rows of codes 37 and 38..63 and rows 0,1,12..15 of every code -> data_o = 8'h00; bit 0 = 0 for all 1024 addresses.
REQ-024 REGISTERED=0, code 22 rows 2..11 -> 8'h40 x9 then 8'h7E; code 19 row 11 -> 8'h7C; code 10 row 6 -> 8'h7C.
REQ-025 REGISTERED=1, drive {6'd30,4'd2} then {6'd19,4'd2} on consecutive cycles -> data_o = 8'hFE one cycle after the first address, 8'h7C one cycle after the second.
REQ-026 REGISTERED=1, assert reset_i asynchronously between clock edges while data_o = 8'hFE -> data_o = 8'h00 immediately, stays 8'h00 until the first edge after release, then shows the addressed row.
REQ-027 Both modes, addr_i = 10'd32 -> data_o = 8'h00.
